// File: rtl/bcu_pkg.sv
// Shared definitions for the branch compare unit: op encodings, FSM states,
// and helpers that say which operands an op consumes.
package bcu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_EQ  = 4'd0;
  localparam logic [OP_W-1:0] OP_NE  = 4'd1;
  localparam logic [OP_W-1:0] OP_LT  = 4'd2;
  localparam logic [OP_W-1:0] OP_GE  = 4'd3;
  localparam logic [OP_W-1:0] OP_LTU = 4'd4;
  localparam logic [OP_W-1:0] OP_GEU = 4'd5;
  localparam logic [OP_W-1:0] OP_LEZ = 4'd6;
  localparam logic [OP_W-1:0] OP_GTZ = 4'd7;
  localparam logic [OP_W-1:0] OP_LTZ = 4'd8;
  localparam logic [OP_W-1:0] OP_GEZ = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Every legal op reads rs; illegal ops read nothing.
  function automatic logic op_needs_rs(input logic [OP_W-1:0] op);
    return op <= OP_GEZ;
  endfunction

  // Only the two-operand compares read rt.
  function automatic logic op_needs_rt(input logic [OP_W-1:0] op);
    return op <= OP_GEU;
  endfunction

  // True once every operand the op consumes has been captured.
  function automatic logic op_operands_ok(input logic [OP_W-1:0] op,
                                          input logic have_rs,
                                          input logic have_rt);
    return (!op_needs_rs(op) || have_rs) && (!op_needs_rt(op) || have_rt);
  endfunction

endpackage

// File: rtl/bcu_cmp_core.sv
// Pure combinational branch condition evaluator.
module bcu_cmp_core
  import bcu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             taken,
  output logic             illegal
);

  logic rs_neg;
  logic rs_zero;

  assign rs_neg  = rs[WIDTH-1];
  assign rs_zero = (rs == '0);

  // Decode the op and evaluate its condition.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_EQ:   taken = (rs == rt);
      OP_NE:   taken = (rs != rt);
      OP_LT:   taken = ($signed(rs) <  $signed(rt));
      OP_GE:   taken = ($signed(rs) >= $signed(rt));
      OP_LTU:  taken = (rs <  rt);
      OP_GEU:  taken = (rs >= rt);
      OP_LEZ:  taken = rs_neg || rs_zero;
      OP_GTZ:  taken = !rs_neg && !rs_zero;
      OP_LTZ:  taken = rs_neg;
      OP_GEZ:  taken = !rs_neg;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/d_branch_cmp_unit.sv
// Branch compare unit: collects operands as forwarding resolves them,
// evaluates the branch condition and hands the result over a valid/ready port.
// Optional statistics counters are built only when BCU_STATS_EN is defined.
module d_branch_cmp_unit
  import bcu_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_W-1:0]      cmp_op,
  input  logic [WIDTH-1:0]     rs_data,
  input  logic [WIDTH-1:0]     rt_data,
  input  logic                 rs_rdy,
  input  logic                 rt_rdy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 taken,
  output logic                 illegal_op,
  output logic [CNT_WIDTH-1:0] resolved_cnt,
  output logic [CNT_WIDTH-1:0] taken_cnt
);

  state_t           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] rs_q, rs_d;
  logic [WIDTH-1:0] rt_q, rt_d;
  logic             have_rs_q, have_rs_d;
  logic             have_rt_q, have_rt_d;
  logic             taken_q, taken_d;
  logic             illegal_q, illegal_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             core_taken;
  logic             core_illegal;

  // Evaluate on the values about to be captured so the flags land with DONE.
  bcu_cmp_core #(.WIDTH(WIDTH)) u_core (
    .op      (op_d),
    .rs      (rs_d),
    .rt      (rt_d),
    .taken   (core_taken),
    .illegal (core_illegal)
  );

  // Next-state, operand capture and result latching.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    have_rs_d   = have_rs_q;
    have_rt_d   = have_rt_q;
    taken_d     = taken_q;
    illegal_d   = illegal_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d      = cmp_op;
          have_rs_d = rs_rdy;
          have_rt_d = rt_rdy;
          if (rs_rdy) rs_d = rs_data;
          if (rt_rdy) rt_d = rt_data;
          state_d = op_operands_ok(cmp_op, rs_rdy, rt_rdy) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!have_rs_q && rs_rdy) begin
          rs_d      = rs_data;
          have_rs_d = 1'b1;
        end
        if (!have_rt_q && rt_rdy) begin
          rt_d      = rt_data;
          have_rt_d = 1'b1;
        end
        if (op_operands_ok(op_q, have_rs_d, have_rt_d)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) state_d = ST_IDLE;

    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      taken_d   = core_taken;
      illegal_d = core_illegal;
    end

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      have_rs_q   <= 1'b0;
      have_rt_q   <= 1'b0;
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      have_rs_q   <= have_rs_d;
      have_rt_q   <= have_rt_d;
      taken_q     <= taken_d;
      illegal_q   <= illegal_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign taken      = taken_q;
  assign illegal_op = illegal_q;

`ifdef BCU_STATS_EN
  logic                 out_hs;
  logic [CNT_WIDTH-1:0] resolved_cnt_q, resolved_cnt_d;
  logic [CNT_WIDTH-1:0] taken_cnt_q, taken_cnt_d;

  assign out_hs = out_valid_q && out_ready && !flush;

  // Saturating counts of delivered results and of taken results.
  always_comb begin
    resolved_cnt_d = resolved_cnt_q;
    taken_cnt_d    = taken_cnt_q;
    if (out_hs) begin
      if (resolved_cnt_q != '1) resolved_cnt_d = resolved_cnt_q + CNT_WIDTH'(1);
      if (taken_q && (taken_cnt_q != '1)) taken_cnt_d = taken_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      resolved_cnt_q <= '0;
      taken_cnt_q    <= '0;
    end else begin
      resolved_cnt_q <= resolved_cnt_d;
      taken_cnt_q    <= taken_cnt_d;
    end
  end

  assign resolved_cnt = resolved_cnt_q;
  assign taken_cnt    = taken_cnt_q;
`else
  assign resolved_cnt = '0;
  assign taken_cnt    = '0;
`endif

endmodule

// File: tb/tb_d_branch_cmp_unit.sv
// Bench for d_branch_cmp_unit: directed corner cases followed by random
// transactions, checked against a behavioural model of the branch rules.
module tb_d_branch_cmp_unit;

  localparam int unsigned W   = 32;
  localparam int unsigned CW  = 2;
  localparam int          CNT_MAX = (1 << CW) - 1;
`ifdef BCU_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready;
  logic [3:0]    cmp_op;
  logic [W-1:0]  rs_data, rt_data;
  logic          rs_rdy, rt_rdy;
  logic          out_valid, out_ready, taken, illegal_op;
  logic [CW-1:0] resolved_cnt, taken_cnt;

  int checks = 0;
  int errors = 0;
  int exp_res = 0;
  int exp_tkn = 0;

  d_branch_cmp_unit #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .cmp_op       (cmp_op),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .rs_rdy       (rs_rdy),
    .rt_rdy       (rt_rdy),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .taken        (taken),
    .illegal_op   (illegal_op),
    .resolved_cnt (resolved_cnt),
    .taken_cnt    (taken_cnt)
  );

  always #5 clk = ~clk;

  // Reference branch rules, evaluated with plain integer arithmetic.
  function automatic bit ref_taken(int op, logic [W-1:0] a, logic [W-1:0] b);
    longint sa, sb, ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (op)
      0: return sa == sb;
      1: return sa != sb;
      2: return sa <  sb;
      3: return sa >= sb;
      4: return ua <  ub;
      5: return ua >= ub;
      6: return sa <= 0;
      7: return sa >  0;
      8: return sa <  0;
      9: return sa >= 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_rescnt"}, 64'(resolved_cnt), STATS ? 64'(exp_res) : 64'd0);
    chk({tag, "_tkncnt"}, 64'(taken_cnt),    STATS ? 64'(exp_tkn) : 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    exp_res = 0;
    exp_tkn = 0;
  endtask

  // One complete transaction: operands arrive rs_dly / rt_dly cycles after
  // the request, the result is held hold cycles before the consumer takes it.
  task automatic txn(input string tag, input int op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input int rs_dly, input int rt_dly,
                     input int hold);
    int  last;
    bit  exp_t, exp_i;
    last  = 0;
    exp_i = (op > 9);
    exp_t = ref_taken(op, a, b);
    if (op <= 9 && rs_dly > last) last = rs_dly;
    if (op <= 5 && rt_dly > last) last = rt_dly;

    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    cmp_op   = 4'(op);
    rs_rdy   = (rs_dly == 0);
    rt_rdy   = (rt_dly == 0);
    rs_data  = (rs_dly == 0) ? a : $urandom;
    rt_data  = (rt_dly == 0) ? b : $urandom;

    for (int c = 1; c <= last; c++) begin
      step();
      chk({tag, "_wait_ov"}, 64'(out_valid), 64'd0);
      chk({tag, "_wait_ir"}, 64'(in_ready), 64'd0);
      in_valid = 1'($urandom);
      cmp_op   = 4'($urandom);
      rs_rdy   = (rs_dly == c) ? 1'b1 : (rs_dly < c) ? 1'($urandom) : 1'b0;
      rt_rdy   = (rt_dly == c) ? 1'b1 : (rt_dly < c) ? 1'($urandom) : 1'b0;
      rs_data  = (rs_dly == c) ? a : $urandom;
      rt_data  = (rt_dly == c) ? b : $urandom;
    end

    step();
    in_valid = 1'($urandom);
    rs_rdy   = 1'($urandom);
    rt_rdy   = 1'($urandom);
    rs_data  = $urandom;
    rt_data  = $urandom;
    chk({tag, "_ov"},      64'(out_valid),  64'd1);
    chk({tag, "_taken"},   64'(taken),      64'(exp_t));
    chk({tag, "_illegal"}, 64'(illegal_op), 64'(exp_i));

    for (int h = 0; h < hold; h++) begin
      step();
      chk({tag, "_hold_ov"},    64'(out_valid),  64'd1);
      chk({tag, "_hold_taken"}, 64'(taken),      64'(exp_t));
      chk({tag, "_hold_ill"},   64'(illegal_op), 64'(exp_i));
    end

    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    rs_rdy    = 1'b0;
    rt_rdy    = 1'b0;
    if (exp_res < CNT_MAX) exp_res++;
    if (exp_t && exp_tkn < CNT_MAX) exp_tkn++;
    chk({tag, "_post_ov"}, 64'(out_valid), 64'd0);
    chk({tag, "_post_ir"}, 64'(in_ready),  64'd1);
    chk_cnts(tag);
  endtask

  initial begin
    int op, rd, td, hd;
    logic [W-1:0] a, b;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; cmp_op = '0;
    rs_data = '0; rt_data = '0; rs_rdy = 1'b0; rt_rdy = 1'b0; out_ready = 1'b0;
    do_reset();
    chk("rst_in_ready",  64'(in_ready),   64'd1);
    chk("rst_out_valid", 64'(out_valid),  64'd0);
    chk("rst_taken",     64'(taken),      64'd0);
    chk("rst_illegal",   64'(illegal_op), 64'd0);
    chk_cnts("rst");

    txn("eq",      0, 32'h0000_1234, 32'h0000_1234, 0, 0, 0);
    txn("lt",      2, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0);
    txn("ltu",     4, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0);
    txn("ne_rt3",  1, 32'd4, 32'd5, 0, 3, 0);
    txn("gez0",    9, 32'd0, 32'd0, 0, 7, 0);
    txn("ill12",  12, 32'd1, 32'd2, 3, 3, 0);
    txn("ge_hold", 3, 32'd7, 32'd7, 0, 0, 4);
    txn("lez_rs2", 6, 32'h8000_0000, 32'd0, 2, 5, 1);

    // Flush while waiting for rt: nothing delivered, counters untouched.
    in_valid = 1'b1; cmp_op = 4'd1; rs_data = 32'd4; rs_rdy = 1'b1; rt_rdy = 1'b0;
    step();
    in_valid = 1'b0; rs_rdy = 1'b0;
    step();
    chk("flw_ov_before", 64'(out_valid), 64'd0);
    flush = 1'b1; in_valid = 1'b1; rt_rdy = 1'b1; rt_data = 32'd5; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; rt_rdy = 1'b0;
    chk("flw_ov", 64'(out_valid), 64'd0);
    chk("flw_ir", 64'(in_ready),  64'd1);
    step();
    chk("flw_ov2", 64'(out_valid), 64'd0);
    chk_cnts("flw");
    out_ready = 1'b0;

    // Flush in DONE outranks out_ready.
    in_valid = 1'b1; cmp_op = 4'd0; rs_data = 32'd3; rt_data = 32'd3;
    rs_rdy = 1'b1; rt_rdy = 1'b1;
    step();
    in_valid = 1'b0; rs_rdy = 1'b0; rt_rdy = 1'b0;
    chk("fld_ov_before", 64'(out_valid), 64'd1);
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b0;
    chk("fld_ov", 64'(out_valid), 64'd0);
    chk("fld_ir", 64'(in_ready),  64'd1);
    chk_cnts("fld");

    // Saturation: five taken results on a 2-bit counter.
    do_reset();
    for (int i = 0; i < 5; i++) txn("sat", 0, 32'd9, 32'd9, 0, 0, 0);
    chk("sat_res", 64'(resolved_cnt), STATS ? 64'd3 : 64'd0);
    chk("sat_tkn", 64'(taken_cnt),    STATS ? 64'd3 : 64'd0);

    // Reset mid-WAIT.
    in_valid = 1'b1; cmp_op = 4'd0; rs_rdy = 1'b0; rt_rdy = 1'b0;
    step();
    in_valid = 1'b0;
    do_reset();
    chk("rstw_ir", 64'(in_ready),  64'd1);
    chk("rstw_ov", 64'(out_valid), 64'd0);
    chk_cnts("rstw");

    // Reset mid-DONE with the consumer ready.
    txn("pre_rstd", 0, 32'd1, 32'd1, 0, 0, 0);
    in_valid = 1'b1; cmp_op = 4'd0; rs_data = 32'd1; rt_data = 32'd1;
    rs_rdy = 1'b1; rt_rdy = 1'b1;
    step();
    in_valid = 1'b0; rs_rdy = 1'b0; rt_rdy = 1'b0; out_ready = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0; out_ready = 1'b0;
    exp_res = 0; exp_tkn = 0;
    chk("rstd_ir",    64'(in_ready),  64'd1);
    chk("rstd_ov",    64'(out_valid), 64'd0);
    chk("rstd_taken", 64'(taken),     64'd0);
    chk_cnts("rstd");

    // Random transactions.
    for (int n = 0; n < 80; n++) begin
      op = int'($urandom_range(15, 0));
      a  = $urandom;
      case ($urandom_range(3, 0))
        0: b = a;
        1: b = $urandom;
        2: b = W'($urandom_range(3, 0));
        default: b = ~a;
      endcase
      if ($urandom_range(3, 0) == 0) a = '0;
      rd = int'($urandom_range(3, 0));
      td = int'($urandom_range(3, 0));
      hd = int'($urandom_range(2, 0));
      txn("rnd", op, a, b, rd, td, hd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/d_branch_cmp_unit.md
D_BRANCH_CMP_UNIT -- requirements
Module: d_branch_cmp_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (legal 8..64).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, statistics counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  abandon any in-flight comparison.
REQ-006 SHALL have port in_valid  input  1  request presented.
REQ-007 SHALL have port in_ready  output  1  unit accepts a request this cycle.
REQ-008 SHALL have port cmp_op  input  4  comparison code.
REQ-009 SHALL have ports rs_data and rt_data  input  WIDTH  operand values, sampled when their ready bit is high.
REQ-010 SHALL have ports rs_rdy and rt_rdy  input  1  operand value is final (forwarding resolved).
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have ports taken  output  1  and illegal_op  output  1  result flags.
REQ-014 SHALL have ports resolved_cnt and taken_cnt  output  CNT_WIDTH  statistics.

Function
REQ-015 SHALL decode cmp_op: 0 EQ, 1 NE, 2 LT signed, 3 GE signed, 4 LTU, 5 GEU, 6 LEZ, 7 GTZ, 8 LTZ, 9 GEZ (6..9 signed rs versus zero); 10..15 illegal.
REQ-016 SHALL, for ops 6..9, treat rt as not needed (rt_rdy ignored).
REQ-017 SHALL, for illegal ops, produce taken=0, illegal_op=1, needing no operands.
REQ-018 SHALL implement states IDLE, WAIT, DONE; in_ready=1 only in IDLE.
REQ-019 SHALL, in IDLE with in_valid=1, capture cmp_op and every operand whose ready bit is high; go to DONE if all needed operands are captured, else WAIT.
REQ-020 SHALL, in WAIT, capture each still-missing operand on the cycle its ready bit is high; go to DONE on the cycle the last needed operand is captured.
REQ-021 SHALL compute taken and illegal_op from captured values on entry to DONE and hold them stable while out_valid=1.
REQ-022 SHALL assert out_valid only in DONE; on out_valid && out_ready, return to IDLE next cycle.
REQ-023 SHALL give latency of exactly 1 cycle from accepted request (all operands ready) to out_valid.
REQ-024 SHALL, on flush=1 in any state, go to IDLE next cycle with out_valid=0; no result is produced and counters are unchanged; flush outranks in_valid and out_ready in the same cycle.
REQ-025 SHALL ignore in_valid outside IDLE.

Reset
REQ-026 SHALL, on reset, set state IDLE, in_ready=1 in the following cycle, out_valid=0, taken=0, illegal_op=0, both counters 0.
REQ-027 SHALL give reset priority over flush and all handshakes, including when reset is asserted mid-WAIT or mid-DONE.

Configuration
REQ-028 SHALL, with BCU_STATS_EN defined, increment resolved_cnt on each out handshake and taken_cnt on each out handshake with taken=1, both saturating at all-ones.
REQ-029 SHALL, without BCU_STATS_EN, keep both counter ports present and driven constant 0 with no counter flops.

Structure
REQ-030 SHALL place the cmp_op encodings, state enum and op-needs-rt helper in shared package bcu_pkg.
REQ-031 SHALL factor the pure combinational compare into one sub-module, bcu_cmp_core (WIDTH-parametrised; inputs op, rs, rt; outputs taken, illegal).

Verification
REQ-032 SHALL cover: EQ, rs=rt=0x0000_1234, both rdy, out_ready=1 -> out_valid next cycle, taken=1, back in IDLE one cycle later.
REQ-033 SHALL cover: LT signed rs=0xFFFF_FFFF, rt=1 -> taken=1; LTU same operands -> taken=0.
REQ-034 SHALL cover: NE with rt_rdy=0 for 3 cycles, then rt=5 with rt_rdy=1, rs=4 -> out_valid the cycle after rt capture, taken=1.
REQ-035 SHALL cover: GEZ rs=0, rt_rdy=0 -> DONE next cycle, taken=1; cmp_op=12 -> illegal_op=1, taken=0.
REQ-036 SHALL cover: out_ready=0 for 4 cycles in DONE -> taken/out_valid held; flush in WAIT -> IDLE, no out_valid, counters unchanged.
REQ-037 SHALL cover, with BCU_STATS_EN, CNT_WIDTH=2: 5 taken results -> resolved_cnt=3, taken_cnt=3 (saturated); reset -> both 0.
